// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - layer geometry, inst bit map, idle word and state enum
package core_ctrl_pkg;

   localparam int ROW      = 8;
   localparam int COL      = 8;
   localparam int IN_W     = 6;
   localparam int K_W      = 3;
   localparam int LEN_NIJ  = IN_W * IN_W;
   localparam int LEN_KIJ  = K_W * K_W;
   localparam int OUT_W    = IN_W - K_W + 1;
   localparam int LEN_ONIJ = OUT_W * OUT_W;
   localparam int ADDR_BW  = 11;
   localparam int X_BASE   = 0;
   localparam int W_BASE   = 36;
   localparam int P_BASE   = 0;

   localparam int INST_W   = 34;
   localparam int KIJ_BW   = 4;
   localparam int PH_BW    = 6;

   // inst bit positions
   localparam int B_ACC      = 33;
   localparam int B_CEN_P    = 32;
   localparam int B_WEN_P    = 31;
   localparam int B_AP_LSB   = 20;
   localparam int B_CEN_X    = 19;
   localparam int B_WEN_X    = 18;
   localparam int B_AX_LSB   = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_IFIFO_WR = 5;
   localparam int B_IFIFO_RD = 4;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXEC     = 1;
   localparam int B_LOAD     = 0;

   // both SRAMs deselected, every strobe low
   localparam logic [INST_W-1:0] IDLE_INST = 34'h1800C0000;

   // last phase value of each fixed-length state
   localparam logic [PH_BW-1:0] WRD_LAST    = PH_BW'(COL);
   localparam logic [PH_BW-1:0] WPE_LAST    = PH_BW'(COL - 1);
   localparam logic [PH_BW-1:0] WDRAIN_LAST = PH_BW'(ROW + COL - 1);
   localparam logic [PH_BW-1:0] XRD_LAST    = PH_BW'(LEN_NIJ);
   localparam logic [PH_BW-1:0] XEX_LAST    = PH_BW'(LEN_NIJ - 1);
   localparam logic [PH_BW-1:0] PDRAIN_LAST = PH_BW'(LEN_NIJ - 1);
   localparam logic [KIJ_BW-1:0] KIJ_LAST   = KIJ_BW'(LEN_KIJ - 1);

   typedef logic [ADDR_BW-1:0] addr_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WRD,
      S_WPE,
      S_WDRAIN,
      S_XRD,
      S_XEX,
      S_PDRAIN,
      S_ACC,
      S_DONE
   } state_t;

endpackage

// File: rtl/core_ctrl_if.sv
// rtl/core_ctrl_if.sv - host handshake, core valid and generated inst bundle
interface core_ctrl_if;
   import core_ctrl_pkg::*;

   logic                start;
   logic                valid;
   logic [INST_W-1:0]   inst;
   logic                busy;
   logic                done;
   logic [KIJ_BW-1:0]   kij;

   modport master (input start, input valid, output inst, output busy, output done, output kij);
   modport slave  (output start, output valid, input inst, input busy, input done, input kij);

endinterface

// File: rtl/core_ctrl_acc.sv
// rtl/core_ctrl_acc.sv - nested output/kernel walk producing psum read addresses
module acc_addr_gen
   import core_ctrl_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  en,
   output addr_t addr,
   output logic  last
);

   localparam int KC_BW = $clog2(K_W);
   localparam int OC_BW = $clog2(OUT_W);
   localparam logic [KC_BW-1:0] K_MAX = KC_BW'(K_W - 1);
   localparam logic [OC_BW-1:0] O_MAX = OC_BW'(OUT_W - 1);

   logic [KC_BW-1:0] kx, ky;
   logic [OC_BW-1:0] ox, oy;
   // row offsets are carried pre-multiplied so no multiplier or divider is needed
   addr_t k_off, ky_off, oy_off;
   logic  k_wrap;

   assign k_wrap = (kx == K_MAX) && (ky == K_MAX);
   assign last   = k_wrap && (ox == O_MAX) && (oy == O_MAX);
   assign addr   = addr_t'(P_BASE) + k_off + oy_off + ky_off + addr_t'(ox) + addr_t'(kx);

   // kx fastest, then ky, then ox, then oy; everything returns to zero after the last step
   always_ff @(posedge clk) begin
      if (reset) begin
         kx     <= '0;
         ky     <= '0;
         ox     <= '0;
         oy     <= '0;
         k_off  <= '0;
         ky_off <= '0;
         oy_off <= '0;
      end else if (en) begin
         k_off <= k_wrap ? '0 : k_off + addr_t'(LEN_NIJ);
         if (kx != K_MAX) begin
            kx <= kx + 1'b1;
         end else begin
            kx <= '0;
            if (ky != K_MAX) begin
               ky     <= ky + 1'b1;
               ky_off <= ky_off + addr_t'(IN_W);
            end else begin
               ky     <= '0;
               ky_off <= '0;
               if (ox != O_MAX) begin
                  ox <= ox + 1'b1;
               end else begin
                  ox <= '0;
                  if (oy != O_MAX) begin
                     oy     <= oy + 1'b1;
                     oy_off <= oy_off + addr_t'(IN_W);
                  end else begin
                     oy     <= '0;
                     oy_off <= '0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - per-layer instruction sequencer driving core.inst
module core_ctrl
   import core_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   core_ctrl_if.master bus
);

   state_t              state;
   logic [PH_BW-1:0]    phase;
   logic [KIJ_BW-1:0]   kij;
   logic [INST_W-1:0]   inst_q;
   logic [INST_W-1:0]   word_d;
   logic                busy_q;
   logic                done_q;
   logic                phase_last;
   logic                acc_en;
   logic                acc_last;
   addr_t               acc_addr;
   addr_t               w_row;
   addr_t               p_row;

   assign w_row  = addr_t'(W_BASE) + addr_t'(kij) * addr_t'(COL);
   assign p_row  = addr_t'(P_BASE) + addr_t'(kij) * addr_t'(LEN_NIJ);
   assign acc_en = (state == S_ACC);

   acc_addr_gen u_acc (
      .clk   (clk),
      .reset (reset),
      .en    (acc_en),
      .addr  (acc_addr),
      .last  (acc_last)
   );

   // instruction for the current state/phase; registered on the next edge
   always_comb begin
      word_d     = IDLE_INST;
      phase_last = 1'b0;
      case (state)
         S_WRD: begin
            if (phase < WRD_LAST) begin
               word_d[B_CEN_X] = 1'b0;
               word_d[B_AX_LSB +: ADDR_BW] = w_row + addr_t'(phase);
            end
            // SRAM data arrives one cycle after the address
            word_d[B_L0_WR] = (phase != '0);
            phase_last = (phase == WRD_LAST);
         end
         S_WPE: begin
            word_d[B_L0_RD] = 1'b1;
            word_d[B_LOAD]  = 1'b1;
            phase_last = (phase == WPE_LAST);
         end
         S_WDRAIN: begin
            phase_last = (phase == WDRAIN_LAST);
         end
         S_XRD: begin
            if (phase < XRD_LAST) begin
               word_d[B_CEN_X] = 1'b0;
               word_d[B_AX_LSB +: ADDR_BW] = addr_t'(X_BASE) + addr_t'(phase);
            end
            word_d[B_L0_WR] = (phase != '0);
            phase_last = (phase == XRD_LAST);
         end
         S_XEX: begin
            word_d[B_L0_RD] = 1'b1;
            word_d[B_EXEC]  = 1'b1;
            phase_last = (phase == XEX_LAST);
         end
         S_PDRAIN: begin
            if (bus.valid) begin
               word_d[B_OFIFO_RD] = 1'b1;
               word_d[B_CEN_P]    = 1'b0;
               word_d[B_WEN_P]    = 1'b0;
               word_d[B_AP_LSB +: ADDR_BW] = p_row + addr_t'(phase);
            end
            phase_last = (phase == PDRAIN_LAST);
         end
         S_ACC: begin
            word_d[B_ACC]   = 1'b1;
            word_d[B_CEN_P] = 1'b0;
            word_d[B_AP_LSB +: ADDR_BW] = acc_addr;
            phase_last = acc_last;
         end
         default: begin
            word_d = IDLE_INST;
         end
      endcase
   end

   // sequencer FSM with phase/kij counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         phase  <= '0;
         kij    <= '0;
         inst_q <= IDLE_INST;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         inst_q <= word_d;
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state  <= S_WRD;
                  phase  <= '0;
                  kij    <= '0;
                  busy_q <= 1'b1;
               end
            end
            S_WRD: begin
               if (phase_last) begin phase <= '0; state <= S_WPE; end
               else phase <= phase + 1'b1;
            end
            S_WPE: begin
               if (phase_last) begin phase <= '0; state <= S_WDRAIN; end
               else phase <= phase + 1'b1;
            end
            S_WDRAIN: begin
               if (phase_last) begin phase <= '0; state <= S_XRD; end
               else phase <= phase + 1'b1;
            end
            S_XRD: begin
               if (phase_last) begin phase <= '0; state <= S_XEX; end
               else phase <= phase + 1'b1;
            end
            S_XEX: begin
               if (phase_last) begin phase <= '0; state <= S_PDRAIN; end
               else phase <= phase + 1'b1;
            end
            S_PDRAIN: begin
               // phase counts drained words and only advances on a read
               if (bus.valid) begin
                  if (phase_last) begin
                     phase <= '0;
                     if (kij == KIJ_LAST) begin
                        state <= S_ACC;
                     end else begin
                        kij   <= kij + 1'b1;
                        state <= S_WRD;
                     end
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
            end
            S_ACC: begin
               if (phase_last) state <= S_DONE;
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.inst = inst_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.kij  = kij;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - randomized layer runs against a behavioural inst-stream model
module tb_core_ctrl;

   localparam logic [33:0] IDLE_W     = 34'h1800C0000;
   localparam int          LAYER_LEN  = 9 * 142 + 144 + 1;
   localparam int          RD_PER_RUN = 9 * 36;

   logic clk;
   logic reset;
   logic start;
   logic valid;

   int n_checks = 0;
   int n_errors = 0;

   core_ctrl_if bus ();

   assign bus.start = start;
   assign bus.valid = valid;

   core_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // observed-timing monitor: layer latency and ofifo read count
   int cyc       = 0;
   int t_first   = 0;
   int t_done    = 0;
   int rd_cnt    = 0;
   bit armed     = 1'b0;
   bit prev_busy = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (bus.busy === 1'b1 && !prev_busy) armed = 1'b1;
      if (armed && bus.inst !== IDLE_W) begin
         armed   = 1'b0;
         t_first = cyc;
      end
      if (bus.done === 1'b1) t_done = cyc;
      if (bus.inst[6] === 1'b1) rd_cnt++;
      prev_busy = (bus.busy === 1'b1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // expected words built straight from the instruction field map
   function automatic logic [33:0] x_word(input bit rd, input int a, input bit l0wr);
      logic [33:0] w;
      w = IDLE_W;
      if (rd) begin
         w[19]   = 1'b0;
         w[17:7] = 11'(a);
      end
      w[2] = l0wr;
      return w;
   endfunction

   function automatic logic [33:0] op_word(input bit ex, input bit ld);
      logic [33:0] w;
      w    = IDLE_W;
      w[3] = 1'b1;
      w[1] = ex;
      w[0] = ld;
      return w;
   endfunction

   function automatic logic [33:0] p_word(input bit acc, input int a);
      logic [33:0] w;
      w        = IDLE_W;
      w[32]    = 1'b0;
      w[30:20] = 11'(a);
      if (acc) begin
         w[33] = 1'b1;
      end else begin
         w[31] = 1'b0;
         w[6]  = 1'b1;
      end
      return w;
   endfunction

   task automatic bg_drive();
      start = 1'($urandom);
      valid = 1'($urandom);
   endtask

   // mode 0: valid high, 1: valid toggles from 1, 2: random valid; abort_kij >= 0 resets mid-XEX
   task automatic run_layer(input int mode, input int abort_kij);
      int   n;
      int   guard;
      int   rd0;
      int   a;
      bit   v;
      bit   tog;
      logic [33:0] e;

      rd0   = rd_cnt;
      start = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", bus.busy, 1);
      check("inst_after_start", bus.inst, IDLE_W);

      for (int k = 0; k < 9; k++) begin
         for (int t = 0; t <= 8; t++) begin
            bg_drive();
            @(negedge clk);
            check($sformatf("wrd k%0d t%0d", k, t), bus.inst, x_word(t < 8, 36 + k * 8 + t, t >= 1));
            if (t == 0) check($sformatf("kij k%0d", k), bus.kij, k);
         end
         for (int t = 0; t < 8; t++) begin
            bg_drive();
            @(negedge clk);
            check($sformatf("wpe k%0d t%0d", k, t), bus.inst, op_word(1'b0, 1'b1));
         end
         for (int t = 0; t < 16; t++) begin
            bg_drive();
            @(negedge clk);
            check($sformatf("wdrain k%0d t%0d", k, t), bus.inst, IDLE_W);
         end
         for (int t = 0; t <= 36; t++) begin
            bg_drive();
            @(negedge clk);
            check($sformatf("xrd k%0d t%0d", k, t), bus.inst, x_word(t < 36, t, t >= 1));
         end
         for (int t = 0; t < 36; t++) begin
            if (k == abort_kij && t == 10) begin
               reset = 1'b1;
               start = 1'b1;
               @(negedge clk);
               check("abort_inst", bus.inst, IDLE_W);
               check("abort_kij", bus.kij, 0);
               check("abort_busy", bus.busy, 0);
               check("abort_done", bus.done, 0);
               reset = 1'b0;
               start = 1'b0;
               @(negedge clk);
               check("abort_still_idle", bus.inst, IDLE_W);
               check("abort_still_notbusy", bus.busy, 0);
               return;
            end
            bg_drive();
            @(negedge clk);
            check($sformatf("xex k%0d t%0d", k, t), bus.inst, op_word(1'b1, 1'b0));
         end
         n     = 0;
         guard = 0;
         tog   = 1'b1;
         while (n < 36 && guard < 400) begin
            case (mode)
               0:       v = 1'b1;
               1:       v = tog;
               default: v = ($urandom_range(0, 3) != 0);
            endcase
            tog   = ~tog;
            valid = v;
            start = 1'($urandom);
            @(negedge clk);
            e = v ? p_word(1'b0, k * 36 + n) : IDLE_W;
            check($sformatf("pdrain k%0d n%0d", k, n), bus.inst, e);
            if (v) n++;
            guard++;
         end
         if (n < 36) check("pdrain_bound", n, 36);
      end

      for (int o = 0; o < 16; o++) begin
         for (int k = 0; k < 9; k++) begin
            a = k * 36 + (o / 4 + k / 3) * 6 + (o % 4 + k % 3);
            bg_drive();
            @(negedge clk);
            check($sformatf("acc o%0d k%0d", o, k), bus.inst, p_word(1'b1, a));
         end
      end

      bg_drive();
      @(negedge clk);
      check("done_inst", bus.inst, IDLE_W);
      check("done_pulse", bus.done, 1);
      check("done_busy", bus.busy, 0);
      start = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      check("post_done", bus.done, 0);
      check("post_inst", bus.inst, IDLE_W);
      check("post_busy", bus.busy, 0);
      check("rd_count", rd_cnt - rd0, RD_PER_RUN);
      if (mode == 0) check("layer_len", t_done - t_first + 1, LAYER_LEN);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b1;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_inst", bus.inst, IDLE_W);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_kij", bus.kij, 0);
      reset = 1'b0;
      start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("idle_inst", bus.inst, IDLE_W);
         check("idle_busy", bus.busy, 0);
      end

      run_layer(1, -1);
      run_layer(0, -1);
      run_layer(2, 4);
      run_layer(2, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
